// File: rtl/baud_cfg_ctrl_pkg.sv
// =============================================================================
// Module : baud_cfg_ctrl_pkg
// Desc   : Shared UART baud-configuration types, field positions and defaults.
// Rev    : 1.0
// =============================================================================
`default_nettype none

package baud_cfg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

    // Nibble positions inside the compensation bytes
    localparam int c_NIB_HI_MSB = 7;
    localparam int c_NIB_HI_LSB = 4;
    localparam int c_NIB_LO_MSB = 3;
    localparam int c_NIB_LO_LSB = 0;

    localparam logic [12:0] c_DEF_ACQ_PERIOD = 13'd43;
    localparam logic [7:0]  c_DEF_POS_COMP   = 8'h71;
    localparam logic [7:0]  c_DEF_NEG_COMP   = 8'h70;
    localparam logic [7:0]  c_DEF_BYTE_COMP  = 8'h48;
    localparam logic [12:0] c_MIN_ACQ_PERIOD = 13'd4;
    localparam logic [3:0]  c_CYCLE_BITS     = 4'd12;

endpackage

`default_nettype wire

// File: rtl/baud_cfg_check.sv
// =============================================================================
// Module : baud_cfg_check
// Desc   : Combinational legality checker for a baud generator configuration.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module baud_cfg_check
    import baud_cfg_ctrl_pkg::*;
#(
    parameter logic [12:0] MIN_ACQ_PERIOD = c_MIN_ACQ_PERIOD,
    parameter logic [3:0]  CYCLE_BITS     = c_CYCLE_BITS
) (
    input  logic [12:0] acqPeriod,
    input  logic [7:0]  posComp,
    input  logic [7:0]  negComp,
    input  logic [7:0]  byteComp,
    output logic        acqOk,
    output logic        byteOk,
    output logic        compOk,
    output logic        legal
);

    logic [4:0] w_nibSum;

    // Five-bit sum so a 15+15 request cannot wrap onto a legal value
    assign w_nibSum = {1'b0, byteComp[c_NIB_HI_MSB:c_NIB_HI_LSB]}
                    + {1'b0, byteComp[c_NIB_LO_MSB:c_NIB_LO_LSB]};

    assign acqOk  = (acqPeriod >= MIN_ACQ_PERIOD);
    assign byteOk = (w_nibSum == {1'b0, CYCLE_BITS});
    assign compOk = (posComp[c_NIB_HI_MSB:c_NIB_HI_LSB] != 4'd0)
                 && (negComp[c_NIB_HI_MSB:c_NIB_HI_LSB] != 4'd0);
    assign legal  = acqOk && byteOk && compOk;

endmodule

`default_nettype wire

// File: rtl/baud_cfg_ctrl.sv
// =============================================================================
// Module : baud_cfg_ctrl
// Desc   : Accepts, checks and applies baud generator configurations at byte
//          boundaries, gating the generator off across each update.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module baud_cfg_ctrl
    import baud_cfg_ctrl_pkg::*;
#(
    parameter logic [12:0] DEF_ACQ_PERIOD = c_DEF_ACQ_PERIOD,
    parameter logic [7:0]  DEF_POS_COMP   = c_DEF_POS_COMP,
    parameter logic [7:0]  DEF_NEG_COMP   = c_DEF_NEG_COMP,
    parameter logic [7:0]  DEF_BYTE_COMP  = c_DEF_BYTE_COMP,
    parameter logic [12:0] MIN_ACQ_PERIOD = c_MIN_ACQ_PERIOD,
    parameter logic [3:0]  CYCLE_BITS     = c_CYCLE_BITS,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [12:0] cfg_acq_period_i,
    input  logic [7:0]  cfg_pos_comp_i,
    input  logic [7:0]  cfg_neg_comp_i,
    input  logic [7:0]  cfg_byte_comp_i,
    input  logic        tx_req_i,
    input  logic        rx_req_i,
    input  logic        tx_busy_i,
    input  logic        rx_busy_i,
    output logic [12:0] AcqPeriod_o,
    output logic [7:0]  PosCompensation_o,
    output logic [7:0]  NegCompensation_o,
    output logic [7:0]  ByteCompensation_o,
    output logic        BaudEn_o,
    output logic        cfg_err_o,
    output logic        cfg_pend_o
);

    localparam int unsigned       c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

    logic w_legal;
    logic w_acqOk;
    logic w_byteOk;
    logic w_compOk;
    logic w_accept;
    logic w_reject;
    logic w_need;
    logic w_busy;

    state_t             r_state;
    logic [c_GAP_W-1:0] r_gapCnt;
    logic               r_pending;
    logic               r_ready;
    logic               r_err;
    logic               r_baudEn;
    logic [12:0]        r_shAcq;
    logic [7:0]         r_shPos;
    logic [7:0]         r_shNeg;
    logic [7:0]         r_shByte;
    logic [12:0]        r_acq;
    logic [7:0]         r_pos;
    logic [7:0]         r_neg;
    logic [7:0]         r_byte;

    baud_cfg_check #(
        .MIN_ACQ_PERIOD (MIN_ACQ_PERIOD),
        .CYCLE_BITS     (CYCLE_BITS)
    ) u_check (
        .acqPeriod (cfg_acq_period_i),
        .posComp   (cfg_pos_comp_i),
        .negComp   (cfg_neg_comp_i),
        .byteComp  (cfg_byte_comp_i),
        .acqOk     (w_acqOk),
        .byteOk    (w_byteOk),
        .compOk    (w_compOk),
        .legal     (w_legal)
    );

    assign w_accept = cfg_valid_i && r_ready && w_legal;
    assign w_reject = cfg_valid_i && r_ready && !w_legal;
    assign w_need   = tx_req_i | rx_req_i;
    assign w_busy   = tx_busy_i | rx_busy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_gapCnt  <= '0;
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            r_baudEn  <= 1'b0;
            r_shAcq   <= DEF_ACQ_PERIOD;
            r_shPos   <= DEF_POS_COMP;
            r_shNeg   <= DEF_NEG_COMP;
            r_shByte  <= DEF_BYTE_COMP;
            r_acq     <= DEF_ACQ_PERIOD;
            r_pos     <= DEF_POS_COMP;
            r_neg     <= DEF_NEG_COMP;
            r_byte    <= DEF_BYTE_COMP;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_pending <= 1'b1;
                r_shAcq   <= cfg_acq_period_i;
                r_shPos   <= cfg_pos_comp_i;
                r_shNeg   <= cfg_neg_comp_i;
                r_shByte  <= cfg_byte_comp_i;
            end
            // Entering LOAD always has pending set, so ready only depends on pending
            r_ready <= !(r_pending || w_accept);

            case (r_state)
                ST_OFF: begin
                    if (r_pending) begin
                        r_state  <= ST_HOLD;
                        r_gapCnt <= '0;
                    end else if (w_need) begin
                        r_state  <= ST_RUN;
                        r_baudEn <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_pending) begin
                        r_state <= ST_DRAIN;
                    end else if (!w_need && !w_busy) begin
                        r_state  <= ST_OFF;
                        r_baudEn <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!w_busy) begin
                        r_state  <= ST_HOLD;
                        r_gapCnt <= '0;
                        r_baudEn <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (r_gapCnt == c_GAP_LAST) begin
                        r_state  <= ST_LOAD;
                        r_gapCnt <= '0;
                    end else begin
                        r_gapCnt <= r_gapCnt + c_GAP_W'(1);
                    end
                end
                ST_LOAD: begin
                    r_acq     <= r_shAcq;
                    r_pos     <= r_shPos;
                    r_neg     <= r_shNeg;
                    r_byte    <= r_shByte;
                    r_pending <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= w_need ? ST_RUN : ST_OFF;
                    r_baudEn  <= w_need;
                end
                default: begin
                    r_state  <= ST_OFF;
                    r_baudEn <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o        = r_ready;
    assign cfg_err_o          = r_err;
    assign cfg_pend_o         = r_pending;
    assign BaudEn_o           = r_baudEn;
    assign AcqPeriod_o        = r_acq;
    assign PosCompensation_o  = r_pos;
    assign NegCompensation_o  = r_neg;
    assign ByteCompensation_o = r_byte;

endmodule

`default_nettype wire

// File: tb/tb_baud_cfg_ctrl.sv
// =============================================================================
// Module : tb_baud_cfg_ctrl
// Desc   : Self-checking bench for baud_cfg_ctrl against a transaction-level model.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_baud_cfg_ctrl;

    localparam int c_GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [12:0] cfg_acq_period_i = '0;
    logic [7:0]  cfg_pos_comp_i = '0;
    logic [7:0]  cfg_neg_comp_i = '0;
    logic [7:0]  cfg_byte_comp_i = '0;
    logic        tx_req_i = 1'b0;
    logic        rx_req_i = 1'b0;
    logic        tx_busy_i = 1'b0;
    logic        rx_busy_i = 1'b0;
    logic [12:0] AcqPeriod_o;
    logic [7:0]  PosCompensation_o;
    logic [7:0]  NegCompensation_o;
    logic [7:0]  ByteCompensation_o;
    logic        BaudEn_o;
    logic        cfg_err_o;
    logic        cfg_pend_o;

    int nChecks = 0;
    int nPass   = 0;

    // Reference state: applied config, one shadow slot, generator enable and update phase
    logic [12:0] m_acq,  s_acq;
    logic [7:0]  m_pos,  s_pos;
    logic [7:0]  m_neg,  s_neg;
    logic [7:0]  m_byte, s_byte;
    logic        m_pend, m_draining, m_en, m_err;
    int          m_gapLeft;

    baud_cfg_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_valid_i        (cfg_valid_i),
        .cfg_ready_o        (cfg_ready_o),
        .cfg_acq_period_i   (cfg_acq_period_i),
        .cfg_pos_comp_i     (cfg_pos_comp_i),
        .cfg_neg_comp_i     (cfg_neg_comp_i),
        .cfg_byte_comp_i    (cfg_byte_comp_i),
        .tx_req_i           (tx_req_i),
        .rx_req_i           (rx_req_i),
        .tx_busy_i          (tx_busy_i),
        .rx_busy_i          (rx_busy_i),
        .AcqPeriod_o        (AcqPeriod_o),
        .PosCompensation_o  (PosCompensation_o),
        .NegCompensation_o  (NegCompensation_o),
        .ByteCompensation_o (ByteCompensation_o),
        .BaudEn_o           (BaudEn_o),
        .cfg_err_o          (cfg_err_o),
        .cfg_pend_o         (cfg_pend_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit isLegal(logic [12:0] a, logic [7:0] p, logic [7:0] n, logic [7:0] b);
        int sum;
        sum = int'(b[7:4]) + int'(b[3:0]);
        return (int'(a) >= 4) && (sum == 12) && (p[7:4] != 4'd0) && (n[7:4] != 4'd0);
    endfunction

    task automatic modelReset();
        m_acq = 13'd43; m_pos = 8'h71; m_neg = 8'h70; m_byte = 8'h48;
        s_acq = 13'd43; s_pos = 8'h71; s_neg = 8'h70; s_byte = 8'h48;
        m_pend = 1'b0; m_draining = 1'b0; m_en = 1'b0; m_err = 1'b0; m_gapLeft = 0;
    endtask

    // Predict the effect of the coming clock edge from the inputs now applied
    task automatic modelEdge();
        bit need, busy, hs, lg;
        if (rst) begin
            modelReset();
            return;
        end
        need = tx_req_i | rx_req_i;
        busy = tx_busy_i | rx_busy_i;
        hs   = cfg_valid_i && !m_pend;
        lg   = isLegal(cfg_acq_period_i, cfg_pos_comp_i, cfg_neg_comp_i, cfg_byte_comp_i);
        if (m_gapLeft > 0) begin
            m_gapLeft--;
            if (m_gapLeft == 0) begin
                m_acq = s_acq; m_pos = s_pos; m_neg = s_neg; m_byte = s_byte;
                m_pend = 1'b0;
                m_en   = need;
            end
        end else if (m_pend && m_draining) begin
            if (!busy) begin
                m_draining = 1'b0;
                m_en       = 1'b0;
                m_gapLeft  = c_GAP + 1;
            end
        end else if (m_pend && m_en) begin
            m_draining = 1'b1;
        end else if (m_pend) begin
            m_gapLeft = c_GAP + 1;
        end else if (!m_en && need) begin
            m_en = 1'b1;
        end else if (m_en && !need && !busy) begin
            m_en = 1'b0;
        end
        m_err = hs && !lg;
        if (hs && lg) begin
            m_pend = 1'b1;
            s_acq = cfg_acq_period_i; s_pos = cfg_pos_comp_i;
            s_neg = cfg_neg_comp_i;   s_byte = cfg_byte_comp_i;
        end
    endtask

    task automatic cyc();
        modelEdge();
        @(posedge clk);
        #1;
        chk("acq",   32'(AcqPeriod_o),        32'(m_acq));
        chk("pos",   32'(PosCompensation_o),  32'(m_pos));
        chk("neg",   32'(NegCompensation_o),  32'(m_neg));
        chk("byte",  32'(ByteCompensation_o), 32'(m_byte));
        chk("en",    32'(BaudEn_o),           32'(m_en));
        chk("ready", 32'(cfg_ready_o),        32'(!m_pend));
        chk("pend",  32'(cfg_pend_o),         32'(m_pend));
        chk("err",   32'(cfg_err_o),          32'(m_err));
    endtask

    task automatic offer(input logic [12:0] a, input logic [7:0] p, input logic [7:0] n, input logic [7:0] b);
        cfg_valid_i = 1'b1;
        cfg_acq_period_i = a; cfg_pos_comp_i = p; cfg_neg_comp_i = n; cfg_byte_comp_i = b;
        cyc();
        cfg_valid_i = 1'b0;
    endtask

    task automatic randCfg();
        logic [3:0] hi, lo;
        cfg_acq_period_i = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(0, 3))
                                                       : 13'($urandom_range(4, 8191));
        hi = 4'($urandom_range(0, 15));
        lo = ($urandom_range(0, 3) == 0 || hi > 4'd12) ? 4'($urandom_range(0, 15)) : 4'd12 - hi;
        cfg_byte_comp_i = {hi, lo};
        cfg_pos_comp_i  = ($urandom_range(0, 7) == 0) ? {4'h0, 4'($urandom)} : 8'($urandom_range(16, 255));
        cfg_neg_comp_i  = ($urandom_range(0, 7) == 0) ? {4'h0, 4'($urandom)} : 8'($urandom_range(16, 255));
    endtask

    initial begin
        int lowCnt;
        int n;
        modelReset();

        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        tx_req_i = 1'b1;
        cyc();
        chk("first_en", 32'(BaudEn_o), 32'd1);

        // Reconfigure while a frame is in flight
        tx_busy_i = 1'b1;
        offer(13'd86, 8'h71, 8'h70, 8'h66);
        repeat (49) cyc();
        chk("held_acq", 32'(AcqPeriod_o), 32'd43);
        tx_busy_i = 1'b0;
        lowCnt = 0;
        repeat (12) begin
            cyc();
            if (!BaudEn_o) lowCnt++;
        end
        chk("gap_len", 32'(lowCnt), 32'(c_GAP + 1));
        chk("new_acq", 32'(AcqPeriod_o), 32'd86);

        offer(13'd50, 8'h71, 8'h70, 8'h57);
        repeat (10) cyc();
        offer(13'd50, 8'h71, 8'h70, 8'h58);
        chk("err_sum13", 32'(cfg_err_o), 32'd1);
        offer(13'd3, 8'h71, 8'h70, 8'h48);
        chk("err_acq3", 32'(cfg_err_o), 32'd1);

        // A second offer stays stalled while the first is pending
        offer(13'd60, 8'h81, 8'h90, 8'h39);
        cfg_valid_i = 1'b1;
        cfg_acq_period_i = 13'd70; cfg_byte_comp_i = 8'h84;
        cyc();
        chk("stall_ready", 32'(cfg_ready_o), 32'd0);
        repeat (20) cyc();
        cfg_valid_i = 1'b0;
        repeat (10) cyc();

        // Update with no requesters: generator stays off
        tx_req_i = 1'b0;
        repeat (4) cyc();
        offer(13'd100, 8'h71, 8'h70, 8'h48);
        n = 0;
        while (AcqPeriod_o != 13'd100 && n < 20) begin
            cyc();
            n++;
        end
        chk("off_apply_lat", 32'(n), 32'd6);

        offer(13'd200, 8'h71, 8'h70, 8'h48);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_pend", 32'(cfg_pend_o), 32'd0);
        chk("rst_acq", 32'(AcqPeriod_o), 32'd43);
        repeat (8) cyc();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) tx_req_i  = ~tx_req_i;
            if ($urandom_range(0, 9) == 0) rx_req_i  = ~rx_req_i;
            if ($urandom_range(0, 5) == 0) tx_busy_i = ~tx_busy_i;
            if ($urandom_range(0, 7) == 0) rx_busy_i = ~rx_busy_i;
            cfg_valid_i = ($urandom_range(0, 3) == 0);
            if (cfg_valid_i) randCfg();
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        cfg_valid_i = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/baud_cfg_ctrl.md
# baud_cfg_ctrl

Sequencing controller for the baudrate generator: owns its enable and its configuration inputs (acquisition period, positive/negative bit compensation, byte compensation). It accepts new configurations from the host register interface with a valid/ready handshake and checks them. It applies each accepted configuration only at a byte boundary, never mid-frame, with the generator gated off for a fixed gap so its counters restart cleanly. It sits between the register block, the TX/RX engines, and the baudrate generator.

## Interface
Parameters:
- DEF_ACQ_PERIOD, 13'd43, acquisition period after reset
- DEF_POS_COMP, 8'h71, positive compensation after reset ([7:4] normal acq count, [3:0] compensated acq count)
- DEF_NEG_COMP, 8'h70, negative compensation after reset
- DEF_BYTE_COMP, 8'h48, byte compensation after reset ([7:4] positive bits, [3:0] negative bits)
- MIN_ACQ_PERIOD, 13'd4, smallest legal acquisition period
- CYCLE_BITS, 4'd12, required sum of the byte compensation nibbles
- GAP_CYCLES, 4, clocks BaudEn_o is held low before a new configuration is loaded (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cfg_valid_i  in  1  host presents a configuration
- cfg_ready_o  out  1  controller accepts the configuration this cycle
- cfg_acq_period_i  in  13  requested acquisition period
- cfg_pos_comp_i  in  8  requested positive compensation
- cfg_neg_comp_i  in  8  requested negative compensation
- cfg_byte_comp_i  in  8  requested byte compensation
- tx_req_i  in  1  TX engine needs baud/acq pulses
- rx_req_i  in  1  RX engine needs baud/acq pulses
- tx_busy_i  in  1  TX mid-frame
- rx_busy_i  in  1  RX mid-frame
- AcqPeriod_o  out  13  to generator
- PosCompensation_o  out  8  to generator
- NegCompensation_o  out  8  to generator
- ByteCompensation_o  out  8  to generator
- BaudEn_o  out  1  generator enable
- cfg_err_o  out  1  one-cycle pulse: an offered configuration was rejected
- cfg_pend_o  out  1  an accepted configuration is waiting to be applied

## Operation
- Shadow register set: holds one accepted configuration. Pending flag: set on accept, cleared in LOAD.
- cfg_ready_o = !pending && state != LOAD.
- Legality checks:
  - Acq period: cfg_acq_period_i ≥ MIN_ACQ_PERIOD.
  - Byte compensation: the nibble sum cfg_byte_comp_i[7:4]+[3:0] = CYCLE_BITS, summed in 5 bits so there is no wrap.
  - Compensation nibbles: each positive/negative normal-count nibble is nonzero.
- Illegal handshake (valid && ready && illegal): data is dropped, cfg_err_o pulses 1 cycle, the pending flag stays 0.
- need = tx_req_i | rx_req_i. busy = tx_busy_i | rx_busy_i.
- FSM states:
  - OFF (reset state): BaudEn_o=0.
    - pending → HOLD.
    - else need → RUN.
  - RUN: BaudEn_o=1.
    - pending → DRAIN.
    - else !need && !busy → OFF.
  - DRAIN: BaudEn_o=1; waits for the frame to finish.
    - !busy → HOLD.
  - HOLD: BaudEn_o=0; gap counter counts GAP_CYCLES clocks, then → LOAD.
  - LOAD: copy shadow to outputs, clear pending.
    - need → RUN.
    - else → OFF.
- Outputs change only in LOAD. They are never modified while BaudEn_o=1.
- Requesters deasserting during DRAIN/HOLD do not abort the update.

## Timing
- Reset values:
  - Config outputs = DEF_* parameters.
  - BaudEn_o=0, cfg_ready_o=1, cfg_err_o=0, cfg_pend_o=0.
  - State OFF; gap counter 0.
- All outputs are registered.
- Accept at edge N → cfg_pend_o=1 from N+1.
- RUN with busy=0:
  - DRAIN one cycle.
  - BaudEn_o low for exactly GAP_CYCLES+1 cycles (HOLD plus LOAD).
  - New values visible the cycle BaudEn_o returns high.
- OFF: new values are applied after GAP_CYCLES+1 cycles, with BaudEn_o staying 0.
- Accept and LOAD in the same cycle are impossible: ready is 0 in LOAD.
- rst mid-operation: shadow is discarded and the outputs return to their defaults on the next edge.
- need rising in OFF → BaudEn_o=1 on the next cycle.
- busy glitching high in HOLD: ignored.

## Structure
- The shared UART package holds:
  - The FSM state enum (OFF, RUN, DRAIN, HOLD, LOAD).
  - The nibble field-position constants for the compensation bytes.
  - The default configuration constants.
- Sub-module baud_cfg_check: the combinational legality checker. It is reused by the register block for read-back status.

## Test plan
- Reset, tx_req_i=1 → next cycle BaudEn_o=1, AcqPeriod_o=43, ByteCompensation_o=8'h48.
- In RUN with tx_busy_i=1 for 50 cycles, offer acq=13'd86, byte 8'h66:
  - Accepted; outputs unchanged while busy.
  - After busy falls, BaudEn_o is low 5 cycles (GAP_CYCLES=4), then high with AcqPeriod_o=86.
- Offer byte_comp 8'h57 (sum 12, legal) then 8'h58 (sum 13) → second is rejected: cfg_err_o pulses, cfg_pend_o unchanged.
- Offer acq=13'd3 → rejected with cfg_err_o. Offer a second config while one is pending → cfg_ready_o=0, held until LOAD.
- In OFF (no requesters), offer a legal config → applied after 5 cycles with BaudEn_o staying 0. Assert rst during HOLD → defaults restored, pending cleared.
